// File: rtl/load_value_predictor_pkg.sv
// Shared types for the load value predictor: FSM state encoding, table entry layout
// and the saturating confidence helper.
package load_value_predictor_pkg;

    localparam int DATA_WIDTH = 32;
    // Confidence storage width; CONF_BITS of the predictor must not exceed this.
    localparam int CONF_W     = 8;

    typedef enum logic [1:0] {
        VP_IDLE,
        VP_WAIT,
        VP_RECOVER
    } vp_state_t;

    // Tag is kept full width with the index/offset bits masked to zero.
    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] tag;
        logic [DATA_WIDTH-1:0] value;
        logic [CONF_W-1:0]     conf;
    } vp_entry_t;

    function automatic logic [CONF_W-1:0] conf_inc(input logic [CONF_W-1:0] c,
                                                   input logic [CONF_W-1:0] max);
        return (c >= max) ? max : c + {{(CONF_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/load_value_predictor_vp_table.sv
// Last-value prediction table: flop array with one combinational read port,
// one synchronous write port and an asynchronous clear.
module vp_table
    import load_value_predictor_pkg::*;
#(
    parameter int INDEX_BITS = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output vp_entry_t             rd_entry,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  vp_entry_t             wr_entry
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    vp_entry_t mem_q [ENTRIES];
    vp_entry_t mem_d [ENTRIES];

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wr_en) begin
            mem_d[wr_idx] = wr_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign rd_entry = mem_q[rd_idx];

endmodule

// File: rtl/load_value_predictor.sv
// Last-value load predictor answering the hazard controller on a D-cache miss and
// resolving against the snooped fill (done on hit, recover on mispredict).
module load_value_predictor
    import load_value_predictor_pkg::*;
#(
    parameter int INDEX_BITS  = 6,
    parameter int CONF_BITS   = 2,
    parameter int CONF_THRESH = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  vp_en,
    input  logic                  recover_en,
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic                  d_cache_req_valid,
    input  logic                  d_cache_req_read,
    input  logic                  d_cache_valid,
    input  logic [DATA_WIDTH-1:0] d_cache_data,
    input  logic                  recovery_done,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  out_valid,
    output logic                  vp_lock,
    output logic                  done,
    output logic                  recover,
    output logic [DATA_WIDTH-1:0] last_predicted_pc
);

    // Handshake: vp_en is accepted only when vp_lock is low (IDLE); vp_lock is the
    // "busy" reply, high from the cycle after accept until done/recover/cancel/timeout.
    // All outputs are registered, so every response appears one cycle after its cause.

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CONF_W-1:0]     CONF_MAX = CONF_W'((1 << CONF_BITS) - 1);
    localparam logic [CONF_W-1:0]     CONF_THR = CONF_W'(CONF_THRESH);
    localparam logic [DATA_WIDTH-1:0] TAG_MASK = {DATA_WIDTH{1'b1}} << (INDEX_BITS + 2);

    function automatic logic [DATA_WIDTH-1:0] tag_of(input logic [DATA_WIDTH-1:0] a);
        return a & TAG_MASK;
    endfunction

    vp_state_t             state_q, state_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic                  out_valid_q, out_valid_d;
    logic                  vp_lock_q, vp_lock_d;
    logic                  done_q, done_d;
    logic                  recover_q, recover_d;
    logic [DATA_WIDTH-1:0] last_pc_q, last_pc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [DATA_WIDTH-1:0] lookup_pc;
    logic [INDEX_BITS-1:0] rd_idx;
    vp_entry_t             rd_entry;
    logic                  rd_hit;
    logic                  wr_en;
    vp_entry_t             wr_entry;
    logic                  resolve;

    // Lookup uses the incoming PC when idle and the latched PC while waiting for the fill.
    assign lookup_pc = (state_q == VP_IDLE) ? pc : last_pc_q;
    assign rd_idx    = lookup_pc[INDEX_BITS+1:2];
    assign rd_hit    = rd_entry.valid && (rd_entry.tag == tag_of(lookup_pc));
    assign resolve   = d_cache_valid && d_cache_req_valid && d_cache_req_read;

    vp_table #(
        .INDEX_BITS (INDEX_BITS)
    ) u_table (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (rd_idx),
        .rd_entry (rd_entry),
        .wr_en    (wr_en),
        .wr_idx   (rd_idx),
        .wr_entry (wr_entry)
    );

    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        last_pc_d   = last_pc_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        recover_d   = recover_q;
        wr_en       = 1'b0;
        wr_entry    = rd_entry;

        case (state_q)
            VP_IDLE: begin
                if (vp_en) begin
                    last_pc_d   = pc;
                    out_d       = rd_hit ? rd_entry.value : '0;
                    out_valid_d = rd_hit && (rd_entry.conf >= CONF_THR);
                    cnt_d       = '0;
                    state_d     = VP_WAIT;
                end
            end
            VP_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!recover_en) begin
                    out_valid_d = 1'b0;
                    state_d     = VP_IDLE;
                end else if (resolve) begin
                    out_valid_d = 1'b0;
                    wr_en       = 1'b1;
                    if (out_valid_q && (d_cache_data == out_q)) begin
                        wr_entry.conf = conf_inc(rd_entry.conf, CONF_MAX);
                        done_d        = 1'b1;
                        state_d       = VP_IDLE;
                    end else if (out_valid_q) begin
                        wr_entry.value = d_cache_data;
                        wr_entry.conf  = '0;
                        recover_d      = 1'b1;
                        state_d        = VP_RECOVER;
                    end else begin
                        // Train-only: strengthen a matching entry, otherwise (re)allocate.
                        if (rd_hit && (rd_entry.value == d_cache_data)) begin
                            wr_entry.conf = conf_inc(rd_entry.conf, CONF_MAX);
                        end else begin
                            wr_entry.valid = 1'b1;
                            wr_entry.tag   = tag_of(last_pc_q);
                            wr_entry.value = d_cache_data;
                            wr_entry.conf  = '0;
                        end
                        state_d = VP_IDLE;
                    end
                end else if (cnt_d == CNT_W'(TIMEOUT)) begin
                    out_valid_d = 1'b0;
                    state_d     = VP_IDLE;
                end
            end
            VP_RECOVER: begin
                if (recovery_done) begin
                    recover_d = 1'b0;
                    state_d   = VP_IDLE;
                end
            end
            default: begin
                state_d = VP_IDLE;
            end
        endcase

        vp_lock_d = (state_d != VP_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= VP_IDLE;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            vp_lock_q   <= 1'b0;
            done_q      <= 1'b0;
            recover_q   <= 1'b0;
            last_pc_q   <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            vp_lock_q   <= vp_lock_d;
            done_q      <= done_d;
            recover_q   <= recover_d;
            last_pc_q   <= last_pc_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out               = out_q;
    assign out_valid         = out_valid_q;
    assign vp_lock           = vp_lock_q;
    assign done              = done_q;
    assign recover           = recover_q;
    assign last_predicted_pc = last_pc_q;

endmodule

// File: tb/tb_load_value_predictor.sv
// Directed bench for load_value_predictor: a table of prediction transactions plus
// hand-written timeout, busy-accept and asynchronous-reset sequences.
module tb_load_value_predictor;
    import load_value_predictor_pkg::*;

    localparam int DW = DATA_WIDTH;

    logic          clk;
    logic          rst_n;
    logic          vp_en;
    logic          recover_en;
    logic [DW-1:0] pc;
    logic          d_cache_req_valid;
    logic          d_cache_req_read;
    logic          d_cache_valid;
    logic [DW-1:0] d_cache_data;
    logic          recovery_done;
    logic [DW-1:0] out;
    logic          out_valid;
    logic          vp_lock;
    logic          done;
    logic          recover;
    logic [DW-1:0] last_predicted_pc;

    int n_tests = 0;
    int n_fail  = 0;

    load_value_predictor #(
        .INDEX_BITS  (6),
        .CONF_BITS   (2),
        .CONF_THRESH (2),
        .TIMEOUT     (8)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .vp_en             (vp_en),
        .recover_en        (recover_en),
        .pc                (pc),
        .d_cache_req_valid (d_cache_req_valid),
        .d_cache_req_read  (d_cache_req_read),
        .d_cache_valid     (d_cache_valid),
        .d_cache_data      (d_cache_data),
        .recovery_done     (recovery_done),
        .out               (out),
        .out_valid         (out_valid),
        .vp_lock           (vp_lock),
        .done              (done),
        .recover           (recover),
        .last_predicted_pc (last_predicted_pc)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] pc;
        logic [DW-1:0] fill;
        int            delay;
        logic          cancel;
        logic [DW-1:0] exp_out;
        logic          exp_ov;
        logic          exp_done;
        logic          exp_rec;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    // Drivers: called at a falling edge, return at a falling edge.
    task automatic accept(input logic [DW-1:0] a);
        vp_en = 1'b1;
        pc    = a;
        @(negedge clk);
        vp_en = 1'b0;
    endtask

    task automatic fill(input logic [DW-1:0] data, input logic cancel);
        d_cache_req_valid = 1'b1;
        d_cache_req_read  = 1'b1;
        d_cache_valid     = 1'b1;
        d_cache_data      = data;
        recover_en        = ~cancel;
        @(negedge clk);
        d_cache_req_valid = 1'b0;
        d_cache_req_read  = 1'b0;
        d_cache_valid     = 1'b0;
        recover_en        = 1'b1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check(  {tag, "_out"},     out,               '0);
        check1( {tag, "_ov"},      out_valid,         1'b0);
        check1( {tag, "_lock"},    vp_lock,           1'b0);
        check1( {tag, "_done"},    done,              1'b0);
        check1( {tag, "_recover"}, recover,           1'b0);
        check(  {tag, "_lastpc"},  last_predicted_pc, '0);
    endtask

    initial begin
        // pc, fill, delay, cancel, exp_out, exp_ov, exp_done, exp_rec
        vecs[0]  = '{32'h400, 32'h1234, 4, 1'b0, 32'h0,    1'b0, 1'b0, 1'b0}; // cold miss
        vecs[1]  = '{32'h400, 32'h1234, 0, 1'b0, 32'h1234, 1'b0, 1'b0, 1'b0}; // conf 0->1
        vecs[2]  = '{32'h400, 32'h1234, 2, 1'b0, 32'h1234, 1'b0, 1'b0, 1'b0}; // conf 1->2
        vecs[3]  = '{32'h400, 32'h1234, 1, 1'b0, 32'h1234, 1'b1, 1'b1, 1'b0}; // confirm, conf 3
        vecs[4]  = '{32'h400, 32'h5678, 3, 1'b0, 32'h1234, 1'b1, 1'b0, 1'b1}; // mispredict
        vecs[5]  = '{32'h400, 32'h5678, 0, 1'b0, 32'h5678, 1'b0, 1'b0, 1'b0}; // conf 0->1
        vecs[6]  = '{32'h400, 32'h9999, 1, 1'b1, 32'h5678, 1'b0, 1'b0, 1'b0}; // cancel beats fill
        vecs[7]  = '{32'h400, 32'h5678, 2, 1'b0, 32'h5678, 1'b0, 1'b0, 1'b0}; // conf 1->2
        vecs[8]  = '{32'h400, 32'h5678, 0, 1'b0, 32'h5678, 1'b1, 1'b1, 1'b0}; // confirm
        vecs[9]  = '{32'h500, 32'hAAAA, 1, 1'b0, 32'h0,    1'b0, 1'b0, 1'b0}; // alias miss, replace
        vecs[10] = '{32'h400, 32'h5678, 0, 1'b0, 32'h0,    1'b0, 1'b0, 1'b0}; // alias miss, replace
        vecs[11] = '{32'h404, 32'h0001, 0, 1'b0, 32'h0,    1'b0, 1'b0, 1'b0}; // other index, cold
        vecs[12] = '{32'h400, 32'h5678, 1, 1'b0, 32'h5678, 1'b0, 1'b0, 1'b0}; // conf 0->1
        vecs[13] = '{32'h400, 32'h7777, 0, 1'b0, 32'h5678, 1'b0, 1'b0, 1'b0}; // new value, conf 0
        vecs[14] = '{32'h400, 32'h7777, 0, 1'b0, 32'h7777, 1'b0, 1'b0, 1'b0}; // conf 0->1
        vecs[15] = '{32'h404, 32'h0001, 0, 1'b0, 32'h0001, 1'b0, 1'b0, 1'b0}; // index 1 intact

        rst_n             = 1'b0;
        vp_en             = 1'b0;
        recover_en        = 1'b1;
        pc                = '0;
        d_cache_req_valid = 1'b0;
        d_cache_req_read  = 1'b0;
        d_cache_valid     = 1'b0;
        d_cache_data      = '0;
        recovery_done     = 1'b0;

        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            accept(vecs[i].pc);
            check(  $sformatf("v%0d_out", i),    out,               vecs[i].exp_out);
            check1( $sformatf("v%0d_ov", i),     out_valid,         vecs[i].exp_ov);
            check(  $sformatf("v%0d_lastpc", i), last_predicted_pc, vecs[i].pc);
            check1( $sformatf("v%0d_lock", i),   vp_lock,           1'b1);
            for (int k = 0; k < vecs[i].delay; k++) begin
                @(negedge clk);
                check1($sformatf("v%0d_lock_wait%0d", i, k), vp_lock, 1'b1);
            end
            fill(vecs[i].fill, vecs[i].cancel);
            check1( $sformatf("v%0d_done", i),     done,      vecs[i].exp_done);
            check1( $sformatf("v%0d_recover", i),  recover,   vecs[i].exp_rec);
            check1( $sformatf("v%0d_lock_end", i), vp_lock,   vecs[i].exp_rec);
            check1( $sformatf("v%0d_ov_end", i),   out_valid, 1'b0);
            check(  $sformatf("v%0d_out_hold", i), out,       vecs[i].exp_out);
            if (vecs[i].exp_done) begin
                @(negedge clk);
                check1($sformatf("v%0d_done_pulse", i), done, 1'b0);
            end
            if (vecs[i].exp_rec) begin
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check1($sformatf("v%0d_recover_hold%0d", i, k), recover, 1'b1);
                end
                recovery_done = 1'b1;
                @(negedge clk);
                recovery_done = 1'b0;
                check1($sformatf("v%0d_recover_fall", i), recover, 1'b0);
                check1($sformatf("v%0d_lock_fall", i),    vp_lock, 1'b0);
            end
            @(negedge clk);
        end

        // Timeout: no fill, lock for exactly 8 WAIT cycles, no table write.
        accept(32'h808);
        check1("to_lock_c1", vp_lock, 1'b1);
        for (int k = 2; k <= 8; k++) begin
            @(negedge clk);
            check1($sformatf("to_lock_c%0d", k), vp_lock, 1'b1);
        end
        @(negedge clk);
        check1("to_lock_off", vp_lock, 1'b0);
        check1("to_done",     done,    1'b0);
        check1("to_recover",  recover, 1'b0);
        @(negedge clk);
        d_cache_data = 32'h42;
        accept(32'h808);
        check("to_no_write", out, 32'h0);
        fill(32'h42, 1'b0);
        @(negedge clk);

        // Busy: vp_en during WAIT is ignored.
        accept(32'h400);
        check("busy_out0", out, 32'h7777);
        vp_en = 1'b1;
        pc    = 32'hBEEF0;
        @(negedge clk);
        vp_en = 1'b0;
        check("busy_lastpc", last_predicted_pc, 32'h400);
        check("busy_out",    out,               32'h7777);
        check1("busy_lock",  vp_lock,           1'b1);
        fill(32'h7777, 1'b0);
        check1("busy_lock_end", vp_lock, 1'b0);
        @(negedge clk);
        accept(32'h400);
        check1("busy_conf_ov", out_valid, 1'b1);
        fill(32'h7777, 1'b0);
        check1("busy_conf_done", done, 1'b1);
        @(negedge clk);

        // Asynchronous reset in the middle of WAIT.
        accept(32'h400);
        check1("rst_pre_ov", out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        accept(32'h400);
        check("rst_cold_out",   out,       32'h0);
        check1("rst_cold_ov",   out_valid, 1'b0);
        fill(32'h7777, 1'b0);
        check1("rst_cold_done", done,      1'b0);
        check1("rst_cold_lock", vp_lock,   1'b0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
